// File: rtl/dtm_pkg.sv
// dtm_pkg: shared TAP states, instruction codes, DMI ops and DTMCS fields
package dtm_pkg;
    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tap_state_e;
    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1f;
    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [3:0] DTMCS_VERSION = 4'd1;
    localparam logic [2:0] DTMCS_IDLE    = 3'd1;
    function automatic logic [31:0] dtmcs_value(input int abits);
        return {17'b0, DTMCS_IDLE, 2'b00, 6'(abits), DTMCS_VERSION};
    endfunction
endpackage

// File: rtl/jtag_tap.sv
// jtag_tap: oversampled JTAG pins, TAP controller, instruction register and tdo retiming
module jtag_tap
    import dtm_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       jtag_tck,
    input  logic       jtag_tms,
    input  logic       jtag_tdi,
    input  logic       dr_lsb,
    output tap_state_e state,
    output logic       tck_rise,
    output logic       tck_fall,
    output logic       tdi,
    output logic [4:0] ir,
    output logic       jtag_tdo
);
    logic [2:0] tck_s;
    logic [1:0] tms_s, tdi_s;
    logic [4:0] ir_sr;
    logic       tms;
    tap_state_e state_n;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tck_s <= '0;
            tms_s <= '0;
            tdi_s <= '0;
        end else begin
            tck_s <= {tck_s[1:0], jtag_tck};
            tms_s <= {tms_s[0], jtag_tms};
            tdi_s <= {tdi_s[0], jtag_tdi};
        end
    end
    assign tck_rise = tck_s[1] & ~tck_s[2];
    assign tck_fall = ~tck_s[1] & tck_s[2];
    assign tms      = tms_s[1];
    assign tdi      = tdi_s[1];
    always_ff @(posedge clk) begin
        if (!resetn) state <= TAP_TLR;
        else if (tck_rise) state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            TAP_TLR:      state_n = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_n = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_n = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      state_n = TAP_TLR;
        endcase
    end
    // Update takes effect on the falling edge inside Update-IR, as in 1149.1
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ir_sr <= '0;
            ir    <= IR_IDCODE;
        end else begin
            if (tck_rise && state == TAP_CAP_IR) ir_sr <= 5'b00001;
            else if (tck_rise && state == TAP_SHIFT_IR) ir_sr <= {tdi, ir_sr[4:1]};
            if (state == TAP_TLR) ir <= IR_IDCODE;
            else if (tck_fall && state == TAP_UPD_IR) ir <= ir_sr;
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) jtag_tdo <= 1'b0;
        else if (state != TAP_SHIFT_IR && state != TAP_SHIFT_DR) jtag_tdo <= 1'b0;
        else if (tck_fall) jtag_tdo <= (state == TAP_SHIFT_IR) ? ir_sr[0] : dr_lsb;
    end
endmodule

// File: rtl/dtm_jtag.sv
// dtm_jtag: RISC-V 0.13 JTAG DTM with IDCODE/DTMCS/DMI/BYPASS registers and DMI initiator
module dtm_jtag
    import dtm_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h2000_0913,
    parameter int          ABITS  = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             dmi_valid,
    output logic             dmi_wr,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata
);
    localparam int DW = ABITS + 34;
    localparam int IW = $clog2(DW);
    tap_state_e       state;
    logic             tck_rise, tck_fall, tdi;
    logic [4:0]       ir;
    logic [DW-1:0]    sr, sr_cap, sr_shift;
    logic [IW-1:0]    msb;
    logic [ABITS-1:0] last_addr, addr;
    logic [31:0]      last_data, data;
    logic [1:0]       op;
    logic             pending, capture, shift, update, req, dmi_reset;
    jtag_tap u_tap (
        .clk      (clk),
        .resetn   (resetn),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .dr_lsb   (sr[0]),
        .state    (state),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tdi      (tdi),
        .ir       (ir),
        .jtag_tdo (jtag_tdo)
    );
    assign capture   = tck_rise && state == TAP_CAP_DR;
    assign shift     = tck_rise && state == TAP_SHIFT_DR;
    assign update    = tck_fall && state == TAP_UPD_DR;
    assign op        = sr[1:0];
    assign data      = sr[33:2];
    assign addr      = sr[DW-1:34];
    assign req       = update && ir == IR_DMI && (op == OP_READ || op == OP_WRITE);
    assign dmi_reset = update && ir == IR_DTMCS && (sr[16] || sr[17]);
    // One physical register serves every DR; tdi enters at the selected length's MSB
    always_comb begin
        msb = (ir == IR_IDCODE || ir == IR_DTMCS) ? IW'(31) : (ir == IR_DMI) ? IW'(DW - 1) : '0;
        sr_cap = (ir == IR_IDCODE) ? DW'(IDCODE)
               : (ir == IR_DTMCS)  ? DW'(dtmcs_value(ABITS))
               : (ir == IR_DMI)    ? {last_addr, last_data, 2'b00} : '0;
        sr_shift = sr >> 1;
        sr_shift[msb] = tdi;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr        <= '0;
            last_addr <= '0;
            last_data <= '0;
            pending   <= 1'b0;
            dmi_valid <= 1'b0;
            dmi_wr    <= 1'b0;
            dmi_addr  <= '0;
            dmi_wdata <= '0;
        end else begin
            if (capture) sr <= sr_cap;
            else if (shift) sr <= sr_shift;
            dmi_valid <= req;
            if (req) begin
                dmi_wr    <= op == OP_WRITE;
                dmi_addr  <= addr;
                last_addr <= addr;
            end
            if (req && op == OP_WRITE) dmi_wdata <= data;
            if (dmi_reset) begin
                pending   <= 1'b0;
                last_addr <= '0;
                last_data <= '0;
            end else if (req) begin
                pending <= op == OP_READ;
                if (op == OP_WRITE) last_data <= data;
            end else if (pending && !dmi_valid) begin
                pending   <= 1'b0;
                last_data <= dmi_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dtm_jtag.sv
// tb_dtm_jtag: randomized JTAG scans against a transaction-level DTM and debug-module model
module tb_dtm_jtag;
    logic        clk = 0, resetn = 0, tck = 0, tms = 0, tdi = 0;
    logic        tdo, dmi_valid, dmi_wr;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata, dmi_rdata = 0;
    logic [31:0] dm_mem [128];
    logic [31:0] m_mem [128];
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [4:0]  cur_ir;
    int          n_chk = 0, n_fail = 0, n_strobe = 0, n_long = 0;
    logic        v_q = 0, s_wr = 0;
    logic [6:0]  s_addr = 0;
    logic [31:0] s_wdata = 0;
    localparam logic [31:0] EXP_IDCODE = 32'h2000_0913;
    localparam logic [31:0] EXP_DTMCS  = 32'h0000_1071;

    always #5 clk = ~clk;

    dtm_jtag dut (
        .clk       (clk),
        .resetn    (resetn),
        .jtag_tck  (tck),
        .jtag_tms  (tms),
        .jtag_tdi  (tdi),
        .jtag_tdo  (tdo),
        .dmi_valid (dmi_valid),
        .dmi_wr    (dmi_wr),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_rdata (dmi_rdata)
    );

    // Debug module: read data appears the cycle after the strobe
    always @(posedge clk) begin
        v_q <= dmi_valid;
        if (dmi_valid) begin
            if (dmi_wr) dm_mem[dmi_addr] <= dmi_wdata;
            dmi_rdata <= dm_mem[dmi_addr];
            n_strobe++;
            s_wr    = dmi_wr;
            s_addr  = dmi_addr;
            s_wdata = dmi_wdata;
        end
        if (dmi_valid && v_q) n_long++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tck_cycle(input logic m, input logic d, output logic o);
        tms = m;
        tdi = d;
        repeat (6) @(posedge clk);
        #1 o = tdo;
        tck = 1;
        repeat (6) @(posedge clk);
        #1 tck = 0;
    endtask

    task automatic tms_seq(input logic [7:0] bits, input int n);
        logic o;
        for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'b0, o);
    endtask

    task automatic scan_ir(input logic [4:0] v, output logic [4:0] out);
        logic o;
        tms_seq(8'b0011, 4);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, v[i], o);
            out[i] = o;
        end
        tms_seq(8'b01, 2);
    endtask

    task automatic scan_dr(input int len, input logic [40:0] v, output logic [40:0] out);
        logic o;
        out = '0;
        tms_seq(8'b001, 3);
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, v[i], o);
            out[i] = o;
        end
        tms_seq(8'b01, 2);
    endtask

    task automatic set_ir(input logic [4:0] v);
        logic [4:0] out;
        scan_ir(v, out);
        check("ir_capture", out, 5'b00001);
        cur_ir = v;
    endtask

    task automatic idcode_scan();
        logic [40:0] out;
        if (cur_ir != 5'h01) set_ir(5'h01);
        scan_dr(32, {9'b0, 32'($urandom)}, out);
        check("idcode", out, EXP_IDCODE);
        check("tdo_idle", tdo, 1'b0);
    endtask

    task automatic dtmcs_scan(input logic [31:0] v);
        logic [40:0] out;
        if (cur_ir != 5'h10) set_ir(5'h10);
        scan_dr(32, {9'b0, v}, out);
        check("dtmcs", out, EXP_DTMCS);
        if (v[16] || v[17]) begin
            m_addr = '0;
            m_data = '0;
        end
    endtask

    task automatic bypass_scan(input logic [4:0] code, input int len, input logic [40:0] v);
        logic [40:0] out, mask;
        if (cur_ir != code) set_ir(code);
        scan_dr(len, v, out);
        mask = (41'h1 << len) - 41'h1;
        check("bypass", out, (v << 1) & mask);
    endtask

    task automatic dmi_op(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        logic [40:0] out;
        int n0;
        if (cur_ir != 5'h11) set_ir(5'h11);
        n0 = n_strobe;
        scan_dr(41, {a, d, op}, out);
        check("dmi_capture", out, {m_addr, m_data, 2'b00});
        repeat (4) @(posedge clk);
        if (op == 2'd1 || op == 2'd2) begin
            check("dmi_strobes", n_strobe - n0, 1);
            check("dmi_wr", s_wr, op == 2'd2);
            check("dmi_addr", s_addr, a);
            m_addr = a;
            if (op == 2'd2) begin
                check("dmi_wdata", s_wdata, d);
                m_mem[a] = d;
                m_data = d;
            end else m_data = m_mem[a];
        end else check("dmi_strobes", n_strobe - n0, 0);
    endtask

    initial begin
        logic [4:0]  code;
        logic [31:0] v;
        logic [40:0] out;
        int n0;
        for (int i = 0; i < 128; i++) begin
            m_mem[i]  = $urandom;
            dm_mem[i] = m_mem[i];
        end
        m_addr = '0;
        m_data = '0;
        cur_ir = 5'h01;
        repeat (5) @(posedge clk);
        #1;
        check("rst_tdo", tdo, 1'b0);
        check("rst_valid", dmi_valid, 1'b0);
        check("rst_wr", dmi_wr, 1'b0);
        check("rst_addr", dmi_addr, 7'h0);
        check("rst_wdata", dmi_wdata, 32'h0);
        resetn = 1;
        repeat (3) @(posedge clk);
        tms_seq(8'b0, 1);
        idcode_scan();
        set_ir(5'h10);
        dtmcs_scan(32'h0);
        dmi_op(7'h04, 32'hDEADBEEF, 2'd2);
        dmi_op(7'h04, 32'h0, 2'd1);
        dmi_op(7'h04, 32'h0, 2'd0);
        dtmcs_scan(32'h0001_0000);
        dmi_op(7'h11, 32'h1234_5678, 2'd3);
        bypass_scan(5'h1f, 4, 41'b1101);
        bypass_scan(5'h05, 4, 41'b1101);
        for (int k = 0; k < 22; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: dmi_op(7'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)));
                6, 7: begin
                    v = $urandom;
                    v[17:16] = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
                    dtmcs_scan(v);
                end
                8: begin
                    do code = 5'($urandom_range(0, 31)); while (code == 5'h01 || code == 5'h10 || code == 5'h11);
                    bypass_scan(code, $urandom_range(2, 16), {9'b0, 32'($urandom)});
                end
                default: idcode_scan();
            endcase
        end
        // Reset with a complete DMI write sitting in Shift-DR, before its Update
        if (cur_ir != 5'h11) set_ir(5'h11);
        tms_seq(8'b001, 3);
        out = {7'h05, 32'hCAFE_F00D, 2'b10};
        for (int i = 0; i < 41; i++) tck_cycle(1'b0, out[i], v[0]);
        n0 = n_strobe;
        resetn = 0;
        repeat (4) @(posedge clk);
        #1;
        check("midscan_rst_tdo", tdo, 1'b0);
        check("midscan_rst_valid", dmi_valid, 1'b0);
        resetn = 1;
        m_addr = '0;
        m_data = '0;
        cur_ir = 5'h01;
        tms_seq(8'b0, 1);
        idcode_scan();
        dmi_op(7'h05, 32'h0, 2'd0);
        check("midscan_no_strobe", n_strobe - n0, 0);
        set_ir(5'h1f);
        tms_seq(8'b001, 3);
        tms_seq(8'b11111, 5);
        cur_ir = 5'h01;
        tms_seq(8'b0, 1);
        idcode_scan();
        check("valid_width", n_long, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
